// File: rtl/prbs_code_source_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared constants and helpers for the PRBS code source:
//   - default Fibonacci feedback masks for the supported word widths
//   - default (non-zero) seed word
//   - parity() feedback helper, evaluated on (dt & taps)
// -----------------------------------------------------------------------------
package prbs_pkg;

  // Widest LFSR the parity helper accepts; narrower words are zero-extended.
  localparam int MAX_W = 64;

  // Maximal-length feedback masks (bit k set => dt[k] enters the XOR).
  localparam logic [6:0]  TAPS_W7  = 7'h60;
  localparam logic [7:0]  TAPS_W8  = 8'h8E;
  localparam logic [14:0] TAPS_W15 = 15'h6000;

  // Reset / recovery word. Must never be zero or the LFSR locks up.
  localparam logic [7:0]  DEFAULT_SEED = 8'hAA;

  // Feedback bit: XOR of the tapped positions.
  function automatic logic parity(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/prbs_code_source_bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Programmable bit-period divider. Produces a one-cycle tick every div+1
// enabled clock cycles. The tick is taken as soon as the running count
// reaches or exceeds div, so lowering div mid-count ticks on the very next
// enabled cycle instead of waiting for a counter wrap.
//
// Ports:
//   clk    in            system clock, rising edge
//   rst_n  in            synchronous active-low reset
//   en     in            count enable; low freezes the count
//   div    in  [DIV_W]   bit period minus one
//   clear  in            restart the period (count to 0), suppresses tick
//   tick   out           one-cycle bit strobe (combinational from the count)
// -----------------------------------------------------------------------------
module bit_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             clear,
  output logic             tick
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_reached;

  assign w_reached = (r_div_cnt >= div);
  assign tick      = en && !clear && w_reached;

  // NOTE: reset is sampled on the clock edge only (synchronous), and state is
  // written with <= so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (clear) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= w_reached ? '0 : r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_code_source.sv
// -----------------------------------------------------------------------------
// prbs_code_source
// Serial pseudo-random code source for the 2FSK transmit chain. A WORD_W-bit
// Fibonacci LFSR word is shifted out MSB first, one bit per programmable bit
// period. Each emitted bit is flagged by code_valid; the MSB of every word
// also raises sync. After the LSB is emitted the LFSR advances (or holds,
// when freeze is set) and the word counter increments. An all-zero next word
// is replaced by SEED and latches lock_err.
//
// Ports:
//   clk         in               system clock, rising edge
//   rst_n       in               synchronous active-low reset
//   en          in               run enable; low pauses everything
//   div         in  [DIV_W]      bit period minus one, in clk cycles
//   load_seed   in               one-cycle restart with seed_in (top priority)
//   seed_in     in  [WORD_W]     word loaded on load_seed
//   freeze      in               repeat the current word at the next boundary
//   code        out              registered serial code bit
//   code_valid  out              one-cycle pulse when code takes a new bit
//   sync        out              high with code_valid for the word's MSB
//   word        out [WORD_W]     word currently being shifted out
//   word_cnt    out [CNT_W]      completed words, wrapping
//   lock_err    out              sticky: a zero word was replaced by SEED
// -----------------------------------------------------------------------------
module prbs_code_source
  import prbs_pkg::*;
#(
  parameter int                WORD_W = 8,
  parameter logic [WORD_W-1:0] TAPS   = TAPS_W8,
  parameter logic [WORD_W-1:0] SEED   = DEFAULT_SEED,
  parameter int                DIV_W  = 16,
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic              load_seed,
  input  logic [WORD_W-1:0] seed_in,
  input  logic              freeze,
  output logic              code,
  output logic              code_valid,
  output logic              sync,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              lock_err
);

  localparam int               IDX_W   = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WORD_W - 1);

  // State
  logic [WORD_W-1:0] r_dt;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              r_lock_err;
  logic              r_code;
  logic              r_code_valid;
  logic              r_sync;

  // Datapath helpers
  logic              w_tick;
  logic              w_fb;
  logic [WORD_W-1:0] w_adv;
  logic              w_adv_zero;
  logic [WORD_W-1:0] w_dt_next;
  logic              w_seed_zero;
  logic [WORD_W-1:0] w_load_word;
  logic              w_last_bit;

  bit_tick_gen #(
    .DIV_W (DIV_W)
  ) u_bit_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .clear (load_seed),
    .tick  (w_tick)
  );

  // NOTE: every signal driven here gets a value on every path (defaults up
  // front), so no latch can be inferred when a branch is added later.
  always_comb begin
    w_fb        = 1'b0;
    w_adv       = r_dt;
    w_adv_zero  = 1'b0;
    w_dt_next   = r_dt;
    w_seed_zero = 1'b0;
    w_load_word = seed_in;
    w_last_bit  = 1'b0;

    // Feedback always comes from the old word, before the shift.
    w_fb        = parity(MAX_W'(r_dt & TAPS));
    w_adv       = freeze ? r_dt : {r_dt[WORD_W-2:0], w_fb};
    // Lock-up guard: a zero word would repeat forever, so recover with SEED.
    w_adv_zero  = (w_adv == '0);
    w_dt_next   = w_adv_zero ? SEED : w_adv;

    w_seed_zero = (seed_in == '0);
    w_load_word = w_seed_zero ? SEED : seed_in;

    w_last_bit  = (r_idx == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dt         <= SEED;
      r_idx        <= IDX_MSB;
      r_word_cnt   <= '0;
      r_lock_err   <= 1'b0;
      r_code       <= 1'b0;
      r_code_valid <= 1'b0;
      r_sync       <= 1'b0;
    end else if (load_seed) begin
      // Restart beats a coincident tick: no bit is emitted, code holds.
      r_dt         <= w_load_word;
      r_idx        <= IDX_MSB;
      r_word_cnt   <= '0;
      r_code_valid <= 1'b0;
      r_sync       <= 1'b0;
      if (w_seed_zero) begin
        r_lock_err <= 1'b1;
      end
    end else if (w_tick) begin
      r_code       <= r_dt[r_idx];
      r_code_valid <= 1'b1;
      r_sync       <= (r_idx == IDX_MSB);
      if (w_last_bit) begin
        // Word boundary: the next word is visible one bit period before
        // its MSB goes out.
        r_idx      <= IDX_MSB;
        r_word_cnt <= r_word_cnt + 1'b1;
        r_dt       <= w_dt_next;
        if (w_adv_zero) begin
          r_lock_err <= 1'b1;
        end
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end else begin
      // Idle or paused: only the strobes drop, everything else holds.
      r_code_valid <= 1'b0;
      r_sync       <= 1'b0;
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign sync       = r_sync;
  assign word       = r_dt;
  assign word_cnt   = r_word_cnt;
  assign lock_err   = r_lock_err;

endmodule

// File: doc/prbs_code_source.md
# prbs_code_source

Parametrised serial pseudo-random code source for the 2FSK transmit chain. It generates a WORD_W-bit Fibonacci LFSR word and shifts it out MSB first, one bit per programmable bit period. Each bit is flagged with a valid strobe, and the first bit of every word carries a sync marker. The serial bit feeds the FSK modulator/NCO frequency select; word count and lock-up status are exported for test and monitoring.

## Interface
Parameters:
- WORD_W, 8: LFSR/word width, ≥ 3.
- TAPS, 8'h8E: feedback mask; bit k set means dt[k] enters the XOR. The default gives taps 7, 3, 2, 1.
- SEED, 8'hAA: reset and recovery word; must be non-zero.
- DIV_W, 16: width of the bit-period divider.
- CNT_W, 8: width of the word counter.

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- en, in, 1: run enable; low pauses the source.
- div, in, DIV_W: bit period minus one, in clk cycles.
- load_seed, in, 1: single-cycle synchronous restart with seed_in.
- seed_in, in, WORD_W: word loaded on load_seed.
- freeze, in, 1: 1 repeats the current word instead of advancing the LFSR.
- code, out, 1: serial code bit, registered.
- code_valid, out, 1: one-cycle pulse when code takes a new bit.
- sync, out, 1: high with code_valid for bit WORD_W-1 of each word.
- word, out, WORD_W: word currently being shifted out.
- word_cnt, out, CNT_W: completed words, wrapping.
- lock_err, out, 1: sticky flag; an all-zero word was replaced by SEED.

## Operation
- State:
  - dt (word)
  - idx (bit index, WORD_W-1 down to 0)
  - div_cnt
  - word_cnt
  - lock_err
- Tick generation:
  - tick when en=1 and div_cnt ≥ div; div_cnt then returns to 0.
  - Otherwise, when en=1, div_cnt increments.
  - Consequences: div=0 ticks every cycle; lowering div mid-count ticks on the next enabled cycle.
- On tick, code ≤ dt[idx], code_valid=1, sync=(idx==WORD_W-1).
- On tick with idx≠0: idx decrements.
- On tick with idx=0 (last bit):
  - idx ≤ WORD_W-1.
  - word_cnt increments, wrapping at 2^CNT_W.
  - If freeze=0, dt ≤ {dt[WORD_W-2:0], ^(dt & TAPS)}, where feedback is computed from the old dt.
  - If freeze=1, dt is unchanged.
- Lock-up guard: if the next dt would be all-zero, load SEED instead and set lock_err.
- en=0 pauses everything: div_cnt, idx, dt, word_cnt and code hold; code_valid=0. There is no index reset on pause.
- load_seed (priority over en and tick):
  - dt ≤ seed_in, or SEED with lock_err set if seed_in==0.
  - idx ≤ WORD_W-1, div_cnt ≤ 0, word_cnt ≤ 0.
  - code holds, code_valid=0.
  - lock_err is otherwise cleared only by reset.
- Reset (rst_n=0 at the clock edge), including mid-word:
  - code=0, code_valid=0, sync=0, dt=SEED, idx=WORD_W-1, div_cnt=0, word_cnt=0, lock_err=0.

## Timing
- All outputs are registered; word reflects dt.
- First tick after reset or load_seed with en=1: occurs after div+1 enabled cycles and emits dt[WORD_W-1].
- Bit rate is clk/(div+1); one word takes WORD_W·(div+1) enabled cycles.
- dt and word_cnt update on the same edge as the LSB's code_valid. word then shows the next word one full bit period before its MSB is emitted.
- Simultaneous load_seed and tick: load wins and no bit is emitted.
- A change of freeze is sampled only at word boundaries.

## Structure
- Package prbs_pkg holds:
  - default TAPS constants per width (7 → 7'h60, 8 → 8'h8E, 15 → 15'h6000)
  - default SEED
  - a feedback function parity(dt & taps)
- Sub-module bit_tick_gen (DIV_W): holds div_cnt; inputs en, div, clear; output tick.
- Top module: shift/LFSR datapath, counters and flags.

## Test plan
- Reset, en=1, div=0, default params:
  - code_valid every cycle.
  - First 8 bits 1,0,1,0,1,0,1,0 with sync on bit 1.
  - word then 0x55, then 0xAB; word_cnt 1, 2.
- div=3: code_valid exactly every 4 cycles. div is changed 7→1 while div_cnt=5; the next tick must occur on the following cycle.
- en dropped for 10 cycles mid-word (after 3 bits): code, word and word_cnt hold and no code_valid. On resume the 4th bit continues the same word.
- load_seed with seed_in=0x00:
  - word=0xAA and lock_err=1, sticky across a subsequent load_seed with seed_in=0x3C.
  - The second load gives word=0x3C and word_cnt=0.
  - load_seed asserted on a tick cycle emits no bit.
- freeze=1 over 3 words:
  - word stays 0xAA and code repeats 10101010.
  - word_cnt advances 1, 2, 3.
  - freeze=0 resumes with 0x55.
- rst_n low mid-word, then high: all outputs return to their reset values. WORD_W=15, TAPS=15'h6000, seed 1 runs 32767 words without an all-zero word or lock_err.
